// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential binary-to-BCD converter (shift-add-3, one bit per
//            clock) with start/busy/done handshake and overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  overflow
);

    localparam int               c_bcd_w    = DIGITS * 4;
    localparam int               c_cnt_w    = $clog2(BIN_W + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(BIN_W);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [0:0]       c_idle     = 1'b0;
    localparam logic [0:0]       c_shift    = 1'b1;

    logic [0:0]          r_state;
    logic [BIN_W-1:0]    r_shift;
    logic [c_bcd_w-1:0]  r_scratch;
    logic                r_ovf;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [c_bcd_w-1:0]  r_bcd;
    logic                r_overflow;

    logic [c_bcd_w-1:0]  w_adj;
    logic [c_bcd_w-1:0]  w_scratch_nxt;
    logic                w_out_bit;

    // Add-3 correction: every nibble that would become >= 10 after doubling
    // is pre-adjusted so the shift carries cleanly into the next digit.
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_adj
            assign w_adj[4*g +: 4] = (r_scratch[4*g +: 4] >= 4'd5)
                                   ? r_scratch[4*g +: 4] + 4'd3
                                   : r_scratch[4*g +: 4];
        end
    endgenerate

    // Adjusted scratch and binary shift register move left as one word; the
    // bit leaving the top digit means the value does not fit in DIGITS.
    assign w_scratch_nxt = {w_adj[c_bcd_w-2:0], r_shift[BIN_W-1]};
    assign w_out_bit     = w_adj[c_bcd_w-1];

    // Control FSM plus datapath; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_idle;
            r_shift    <= '0;
            r_scratch  <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_shift   <= bin;
                        r_scratch <= '0;
                        r_ovf     <= 1'b0;
                        r_cnt     <= c_cnt_init;
                        r_busy    <= 1'b1;
                        r_state   <= c_shift;
                    end
                end
                c_shift: begin
                    r_scratch <= w_scratch_nxt;
                    r_shift   <= r_shift << 1;
                    r_ovf     <= r_ovf | w_out_bit;
                    r_cnt     <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_bcd      <= w_scratch_nxt;
                        r_overflow <= r_ovf | w_out_bit;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Purpose  : Self-checking bench for bin2bcd_seq; a 5-digit and a 4-digit
//            instance run the same stimulus and are compared to a decimal
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    localparam int BIN_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [BIN_W-1:0]  bin = '0;
    logic              busy5, done5, ovf5;
    logic [19:0]       bcd5;
    logic              busy4, done4, ovf4;
    logic [15:0]       bcd4;

    int checks   = 0;
    int failures = 0;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy5), .done(done5), .bcd(bcd5), .overflow(ovf5)
    );

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy4), .done(done4), .bcd(bcd4), .overflow(ovf4)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits of the value, low 'digits' kept.
    function automatic logic [31:0] ref_bcd(input int unsigned v, input int digits);
        logic [31:0] r = '0;
        for (int i = 0; i < digits; i++) begin
            r |= 32'(v % 10) << (4 * i);
            v  = v / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int unsigned v, input int digits);
        int unsigned lim = 1;
        for (int i = 0; i < digits; i++) lim *= 10;
        return v >= lim;
    endfunction

    // Launch a conversion from the current (post-edge) time, optionally
    // pulsing a second start while busy; returns just after the done edge.
    task automatic run_conv(input int unsigned value, input int inject_cyc);
        int  k = 0;
        bit  busy_ok = 1'b1;
        start = 1'b1;
        bin   = value[BIN_W-1:0];
        @(posedge clk); #1;
        start = 1'b0;
        bin   = BIN_W'($urandom);
        while (k < 40) begin
            if (!(busy5 && busy4)) busy_ok = 1'b0;
            if (k + 1 == inject_cyc) begin
                start = 1'b1;
                bin   = 16'd1111;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
            if (done5 || done4) break;
        end
        start = 1'b0;
        check_val("latency", 32'(k), 32'(BIN_W));
        check_val("busy_during", 32'(busy_ok), 32'd1);
        check_val("done_both", {30'd0, done5, done4}, 32'd3);
        check_val("busy_at_done", {30'd0, busy5, busy4}, 32'd0);
        check_val($sformatf("bcd5_%0d", value), 32'(bcd5), ref_bcd(value, 5));
        check_val($sformatf("ovf5_%0d", value), 32'(ovf5), 32'(ref_ovf(value, 5)));
        check_val($sformatf("bcd4_%0d", value), 32'(bcd4), ref_bcd(value, 4));
        check_val($sformatf("ovf4_%0d", value), 32'(ovf4), 32'(ref_ovf(value, 4)));
    endtask

    task automatic idle_no_done(input string tag, input int cycles);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done5 || done4 || busy5 || busy4) seen = 1'b1;
        end
        check_val(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [19:0] held;
        int unsigned v;

        // Reset state
        #1;
        check_val("rst_outputs5", {11'd0, busy5, done5, ovf5, bcd5}, 32'd0);
        check_val("rst_outputs4", {15'd0, busy4, done4, ovf4, bcd4}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero input, then done must be a single-cycle pulse
        run_conv(0, 0);
        @(posedge clk); #1;
        check_val("done_width", {30'd0, done5, done4}, 32'd0);

        // Directed values, back-to-back (start asserted in the done cycle)
        run_conv(65535, 0);
        run_conv(1234, 0);
        run_conv(9, 0);
        run_conv(12345, 0);
        run_conv(9999, 0);
        run_conv(10000, 0);

        // Start while busy is ignored, no second conversion afterwards
        run_conv(4321, 5);
        idle_no_done("no_second_conv", 24);
        held = bcd5;
        check_val("bcd_stable", 32'(held), 32'h04321);

        run_conv(777, 0);

        // Randomized values
        for (int n = 0; n < 24; n++) begin
            v = $urandom_range(65535, 0);
            if (n % 4 == 0) v = $urandom_range(10999, 9990);
            run_conv(v, 0);
        end

        // Reset in the middle of a conversion of 500
        start = 1'b1;
        bin   = 16'd500;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst5", {11'd0, busy5, done5, ovf5, bcd5}, 32'd0);
        check_val("midrst4", {15'd0, busy4, done4, ovf4, bcd4}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_no_done("no_done_after_rst", 30);
        check_val("bcd_after_rst", 32'(bcd5), 32'd0);

        run_conv(500, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
